// File: rtl/traffic_pkg.sv
// ============================================================================
// Module : traffic_pkg
// Brief  : Shared light codes, tracked-phase encodings and default phase
//          lengths for the intersection controller and its monitor.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package traffic_pkg;

  localparam logic [3:0] C_RED    = 4'b1000;
  localparam logic [3:0] C_YELLOW = 4'b0100;
  localparam logic [3:0] C_LEFT   = 4'b0010;
  localparam logic [3:0] C_GREEN  = 4'b0001;
  localparam logic [3:0] C_NONE   = 4'b0000;

  localparam logic [1:0] W_RED    = 2'b10;
  localparam logic [1:0] W_GREEN  = 2'b01;
  localparam logic [1:0] W_NONE   = 2'b00;
  localparam logic [1:0] W_BAD    = 2'b11;

  localparam int DEF_GREEN_LEN      = 20;
  localparam int DEF_YEL_LEN        = 2;
  localparam int DEF_LEFT_LEN       = 10;
  localparam int DEF_RED_LEN        = 34;
  localparam int DEF_WALK_SOLID_LEN = 14;
  localparam int DEF_WALK_BLINK_LEN = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_GREEN = 3'd2,
    ST_YEL1  = 3'd3,
    ST_LEFT  = 3'd4,
    ST_YEL2  = 3'd5,
    ST_RED   = 3'd6
  } phase_t;

  // Car light code shown while a tracked phase is active.
  function automatic logic [3:0] phase_car_code(input phase_t p);
    case (p)
      ST_GREEN:        phase_car_code = C_GREEN;
      ST_YEL1, ST_YEL2: phase_car_code = C_YELLOW;
      ST_LEFT:         phase_car_code = C_LEFT;
      ST_RED:          phase_car_code = C_RED;
      default:         phase_car_code = C_NONE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/traffic_walk_chk.sv
// ============================================================================
// Module : traffic_walk_chk
// Brief  : Walker pattern checker for a car RED phase: solid GREEN, then a
//          00/01 blink starting with 00, then RED until the phase ends.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module traffic_walk_chk
  import traffic_pkg::*;
#(
  parameter int SOLID_LEN = DEF_WALK_SOLID_LEN,
  parameter int BLINK_LEN = DEF_WALK_BLINK_LEN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_en,
  input  logic       i_red_entry,
  input  logic [1:0] i_walker,
  output logic       o_err
);

  localparam logic [6:0] C_SOLID_END = 7'(SOLID_LEN);
  localparam logic [6:0] C_BLINK_END = 7'(SOLID_LEN + BLINK_LEN);

  logic [6:0] r_pos;
  logic [6:0] w_pos;
  logic [6:0] w_off;
  logic [1:0] w_exp;

  // The entry sample itself is position 0 of the pattern.
  assign w_pos = i_red_entry ? 7'd0 : r_pos;
  assign w_off = w_pos - C_SOLID_END;

  always_comb begin
    w_exp = W_RED;
    if (w_pos < C_SOLID_END)
      w_exp = W_GREEN;
    else if (w_pos < C_BLINK_END)
      w_exp = w_off[0] ? W_GREEN : W_NONE;
  end

  assign o_err = (i_en || i_red_entry) && (i_walker != w_exp);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_pos <= 7'd0;
    else if (i_red_entry)
      r_pos <= 7'd1;
    else if (i_en && r_pos != 7'd127)
      r_pos <= r_pos + 7'd1;
  end

endmodule

`default_nettype wire

// File: rtl/traffic_monitor.sv
// ============================================================================
// Module : traffic_monitor
// Brief  : Passive checker of car/walker light codes: phase sequence, phase
//          lengths, encoding and pedestrian conflicts. Optional walker blink
//          checking inside RED is built when TRAFFIC_MON_BLINK_CHK_EN is set.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module traffic_monitor
  import traffic_pkg::*;
#(
  parameter int GREEN_LEN = DEF_GREEN_LEN,
  parameter int YEL_LEN   = DEF_YEL_LEN,
  parameter int LEFT_LEN  = DEF_LEFT_LEN,
  parameter int RED_LEN   = DEF_RED_LEN
`ifdef TRAFFIC_MON_BLINK_CHK_EN
  ,
  parameter int WALK_SOLID_LEN = DEF_WALK_SOLID_LEN,
  parameter int WALK_BLINK_LEN = DEF_WALK_BLINK_LEN
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic [3:0] i_car_traffic,
  input  logic [1:0] i_walker_traffic,
  output logic [2:0] o_phase,
  output logic       o_err_code,
  output logic       o_err_seq,
  output logic       o_err_len,
  output logic       o_err_conflict,
  output logic [3:0] o_err_sticky,
  output logic [7:0] o_cycle_cnt
);

  localparam logic [6:0] C_L_GREEN = 7'(GREEN_LEN);
  localparam logic [6:0] C_L_YEL   = 7'(YEL_LEN);
  localparam logic [6:0] C_L_LEFT  = 7'(LEFT_LEN);
  localparam logic [6:0] C_L_RED   = 7'(RED_LEN);
  localparam logic [6:0] C_SAT     = 7'd127;

  phase_t     r_state, w_nxt_state, w_legal_next, w_obs_phase;
  logic [6:0] r_cnt, w_nxt_cnt, w_len_exp;
  logic       r_chk, w_nxt_chk;
  logic [7:0] r_cycle, w_nxt_cycle;
  logic       w_car_ok, w_code_ok, w_same, w_legal, w_walk_err;
  logic       w_e_code, w_e_seq, w_e_len, w_e_conflict;

  assign w_car_ok  = (i_car_traffic != C_NONE) &&
                     ((i_car_traffic & (i_car_traffic - 4'd1)) == 4'd0);
  assign w_code_ok = w_car_ok && (i_walker_traffic != W_BAD);
  assign w_same    = (i_car_traffic == phase_car_code(r_state));
  assign w_legal   = (i_car_traffic == phase_car_code(w_legal_next));

  always_comb begin
    w_legal_next = ST_IDLE;
    w_len_exp    = 7'd0;
    case (r_state)
      ST_GREEN: begin w_legal_next = ST_YEL1;  w_len_exp = C_L_GREEN; end
      ST_YEL1:  begin w_legal_next = ST_LEFT;  w_len_exp = C_L_YEL;   end
      ST_LEFT:  begin w_legal_next = ST_YEL2;  w_len_exp = C_L_LEFT;  end
      ST_YEL2:  begin w_legal_next = ST_RED;   w_len_exp = C_L_YEL;   end
      ST_RED:   begin w_legal_next = ST_GREEN; w_len_exp = C_L_RED;   end
      default:  ;
    endcase
  end

  // A YELLOW seen out of sequence is attributed to whichever YELLOW it follows.
  always_comb begin
    w_obs_phase = ST_IDLE;
    case (i_car_traffic)
      C_GREEN:  w_obs_phase = ST_GREEN;
      C_LEFT:   w_obs_phase = ST_LEFT;
      C_RED:    w_obs_phase = ST_RED;
      C_YELLOW: w_obs_phase = (r_state == ST_GREEN) ? ST_YEL1 : ST_YEL2;
      default:  ;
    endcase
  end

`ifdef TRAFFIC_MON_BLINK_CHK_EN
  logic w_red_entry, w_walk_en;

  assign w_red_entry = i_start && (r_state == ST_YEL2) && w_code_ok &&
                       (i_car_traffic == C_RED);
  assign w_walk_en   = i_start && (r_state == ST_RED) && r_chk && w_code_ok && w_same;

  traffic_walk_chk #(
    .SOLID_LEN (WALK_SOLID_LEN),
    .BLINK_LEN (WALK_BLINK_LEN)
  ) u_walk_chk (
    .clk         (clk),
    .reset       (reset),
    .i_en        (w_walk_en),
    .i_red_entry (w_red_entry),
    .i_walker    (i_walker_traffic),
    .o_err       (w_walk_err)
  );
`else
  assign w_walk_err = 1'b0;
`endif

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_cnt    = r_cnt;
    w_nxt_chk    = r_chk;
    w_nxt_cycle  = r_cycle;
    w_e_code     = 1'b0;
    w_e_seq      = 1'b0;
    w_e_len      = 1'b0;
    w_e_conflict = 1'b0;
    if (!i_start) begin
      w_nxt_state = ST_IDLE;
      w_nxt_cnt   = 7'd0;
      w_nxt_chk   = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: w_nxt_state = ST_SYNC;
        ST_SYNC: begin
          if (!w_code_ok)
            w_e_code = 1'b1;
          else if (i_car_traffic != C_YELLOW) begin
            w_nxt_state = w_obs_phase;
            w_nxt_cnt   = 7'd1;
            w_nxt_chk   = 1'b0;
          end
        end
        default: begin
          w_e_conflict = (i_walker_traffic == W_GREEN) && (i_car_traffic != C_RED);
          if (!w_code_ok)
            w_e_code = 1'b1;
          else if (w_same) begin
            if (r_cnt != C_SAT) w_nxt_cnt = r_cnt + 7'd1;
            w_e_len = (r_cnt == C_SAT - 7'd1);
          end else if (w_legal) begin
            w_nxt_state = w_legal_next;
            w_nxt_cnt   = 7'd1;
            w_nxt_chk   = 1'b1;
            // A saturated phase has already reported once.
            w_e_len     = r_chk && (r_cnt != C_SAT) && (r_cnt != w_len_exp);
            if (r_state == ST_RED) w_nxt_cycle = r_cycle + 8'd1;
          end else begin
            w_e_seq     = 1'b1;
            w_nxt_state = w_obs_phase;
            w_nxt_cnt   = 7'd1;
            w_nxt_chk   = 1'b0;
          end
          w_e_code = w_e_code | w_walk_err;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_cnt          <= 7'd0;
      r_chk          <= 1'b0;
      r_cycle        <= 8'd0;
      o_err_code     <= 1'b0;
      o_err_seq      <= 1'b0;
      o_err_len      <= 1'b0;
      o_err_conflict <= 1'b0;
      o_err_sticky   <= 4'd0;
    end else begin
      r_state        <= w_nxt_state;
      r_cnt          <= w_nxt_cnt;
      r_chk          <= w_nxt_chk;
      r_cycle        <= w_nxt_cycle;
      o_err_code     <= w_e_code;
      o_err_seq      <= w_e_seq;
      o_err_len      <= w_e_len;
      o_err_conflict <= w_e_conflict;
      // Bit 0 conflict, bit 1 len, bit 2 seq, bit 3 code.
      if (!i_start)
        o_err_sticky <= 4'd0;
      else
        o_err_sticky <= o_err_sticky | {w_e_code, w_e_seq, w_e_len, w_e_conflict};
    end
  end

  assign o_phase     = r_state;
  assign o_cycle_cnt = r_cycle;

endmodule

`default_nettype wire

// File: tb/tb_traffic_monitor.sv
// ============================================================================
// Module : tb_traffic_monitor
// Brief  : Directed self-checking bench for traffic_monitor.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_traffic_monitor;

  localparam logic [3:0] K_RED = 4'b1000, K_YEL = 4'b0100, K_LEFT = 4'b0010, K_GRN = 4'b0001;
  localparam logic [1:0] P_RED = 2'b10, P_GRN = 2'b01, P_NONE = 2'b00, P_BAD = 2'b11;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] car = 4'b0000;
  logic [1:0] walk = 2'b10;
  logic [2:0] o_phase;
  logic       o_err_code, o_err_seq, o_err_len, o_err_conflict;
  logic [3:0] o_err_sticky;
  logic [7:0] o_cycle_cnt;

  int n_vec = 0;
  int n_bad = 0;
  int cnt_code, cnt_seq, cnt_len, cnt_conf;
  logic [2:0] first_phase;

  traffic_monitor dut (
    .clk              (clk),
    .reset            (reset),
    .i_start          (start),
    .i_car_traffic    (car),
    .i_walker_traffic (walk),
    .o_phase          (o_phase),
    .o_err_code       (o_err_code),
    .o_err_seq        (o_err_seq),
    .o_err_len        (o_err_len),
    .o_err_conflict   (o_err_conflict),
    .o_err_sticky     (o_err_sticky),
    .o_cycle_cnt      (o_cycle_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] std_walk(input int i, input bit bad);
    if (bad && i == 14) return P_GRN;
    if (i < 14) return P_GRN;
    if (i < 20) return ((i - 14) % 2 == 0) ? P_NONE : P_GRN;
    return P_RED;
  endfunction

  task automatic apply(input logic [3:0] c, input logic [1:0] w);
    car  = c;
    walk = w;
    @(posedge clk);
    #1;
    cnt_code += int'(o_err_code);
    cnt_seq  += int'(o_err_seq);
    cnt_len  += int'(o_err_len);
    cnt_conf += int'(o_err_conflict);
  endtask

  task automatic drive_phase(input logic [3:0] c, input int n, input bit bad_blink);
    for (int i = 0; i < n; i++) begin
      apply(c, (c == K_RED) ? std_walk(i, bad_blink) : P_RED);
      if (i == 0) first_phase = o_phase;
    end
  endtask

  task automatic clear_counts();
    cnt_code = 0; cnt_seq = 0; cnt_len = 0; cnt_conf = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (o_phase !== 3'd0) begin n_bad++; $display("FAIL reset_phase: got %0d expected 0", o_phase); end
    n_vec++; if ({o_err_code, o_err_seq, o_err_len, o_err_conflict} !== 4'b0) begin n_bad++; $display("FAIL reset_pulses: got %b expected 0000", {o_err_code, o_err_seq, o_err_len, o_err_conflict}); end
    n_vec++; if (o_err_sticky !== 4'd0 || o_cycle_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_sticky_cnt: got %b/%0d expected 0000/0", o_err_sticky, o_cycle_cnt); end
    reset = 1'b0;
  endtask

  task automatic test_golden();
    logic [2:0] exp_ph [5] = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd2};
    logic [3:0] codes  [5] = '{K_YEL, K_LEFT, K_YEL, K_RED, K_GRN};
    int         lens   [5] = '{2, 10, 2, 34, 20};
    clear_counts();
    start = 1'b1;
    drive_phase(K_GRN, 21, 1'b0);
    n_vec++; if (first_phase !== 3'd1) begin n_bad++; $display("FAIL golden_sync: got %0d expected 1", first_phase); end
    n_vec++; if (o_phase !== 3'd2) begin n_bad++; $display("FAIL golden_green: got %0d expected 2", o_phase); end
    for (int cyc = 0; cyc < 3; cyc++) begin
      for (int p = 0; p < 5; p++) begin
        drive_phase(codes[p], lens[p], 1'b0);
        n_vec++; if (first_phase !== exp_ph[p]) begin n_bad++; $display("FAIL golden_phase c%0d p%0d: got %0d expected %0d", cyc, p, first_phase, exp_ph[p]); end
      end
    end
    n_vec++; if (cnt_code + cnt_seq + cnt_len + cnt_conf != 0) begin n_bad++; $display("FAIL golden_errors: got %0d/%0d/%0d/%0d expected none", cnt_code, cnt_seq, cnt_len, cnt_conf); end
    n_vec++; if (o_cycle_cnt !== 8'd3) begin n_bad++; $display("FAIL golden_cycles: got %0d expected 3", o_cycle_cnt); end
    n_vec++; if (o_err_sticky !== 4'd0) begin n_bad++; $display("FAIL golden_sticky: got %b expected 0000", o_err_sticky); end
  endtask

  task automatic test_short_left();
    clear_counts();
    drive_phase(K_YEL, 2, 1'b0);
    drive_phase(K_LEFT, 9, 1'b0);
    n_vec++; if (o_err_len !== 1'b0) begin n_bad++; $display("FAIL short_left_early: got %b expected 0", o_err_len); end
    apply(K_YEL, P_RED);
    n_vec++; if (o_err_len !== 1'b1 || o_phase !== 3'd5) begin n_bad++; $display("FAIL short_left_pulse: got len=%b phase=%0d expected 1/5", o_err_len, o_phase); end
    apply(K_YEL, P_RED);
    n_vec++; if (o_err_len !== 1'b0) begin n_bad++; $display("FAIL short_left_width: got %b expected 0", o_err_len); end
    drive_phase(K_RED, 34, 1'b0);
    drive_phase(K_GRN, 20, 1'b0);
    n_vec++; if (o_err_sticky !== 4'b0010) begin n_bad++; $display("FAIL short_left_sticky: got %b expected 0010", o_err_sticky); end
    n_vec++; if (cnt_len != 1 || o_cycle_cnt !== 8'd4) begin n_bad++; $display("FAIL short_left_count: got len=%0d cyc=%0d expected 1/4", cnt_len, o_cycle_cnt); end
  endtask

  task automatic test_skip();
    clear_counts();
    apply(K_RED, P_RED);
    n_vec++; if (o_err_seq !== 1'b1 || o_phase !== 3'd6 || o_err_len !== 1'b0) begin n_bad++; $display("FAIL skip_seq: got seq=%b phase=%0d len=%b expected 1/6/0", o_err_seq, o_phase, o_err_len); end
    repeat (5) apply(K_RED, P_RED);
    apply(K_GRN, P_RED);
    n_vec++; if (o_err_len !== 1'b0 || o_err_seq !== 1'b0 || o_phase !== 3'd2) begin n_bad++; $display("FAIL skip_red_unchecked: got len=%b seq=%b phase=%0d expected 0/0/2", o_err_len, o_err_seq, o_phase); end
    n_vec++; if (o_cycle_cnt !== 8'd5 || cnt_seq != 1 || cnt_len != 0) begin n_bad++; $display("FAIL skip_counts: got cyc=%0d seq=%0d len=%0d expected 5/1/0", o_cycle_cnt, cnt_seq, cnt_len); end
  endtask

  task automatic test_conflict();
    clear_counts();
    start = 1'b0;
    apply(K_GRN, P_RED);
    n_vec++; if (o_phase !== 3'd0 || o_err_sticky !== 4'd0 || o_cycle_cnt !== 8'd5) begin n_bad++; $display("FAIL stop_state: got phase=%0d sticky=%b cyc=%0d expected 0/0000/5", o_phase, o_err_sticky, o_cycle_cnt); end
    start = 1'b1;
    repeat (5) apply(K_GRN, P_RED);
    apply(K_GRN, P_GRN);
    n_vec++; if (o_err_conflict !== 1'b1) begin n_bad++; $display("FAIL conflict_pulse: got %b expected 1", o_err_conflict); end
    apply(K_GRN, P_RED);
    n_vec++; if (o_err_conflict !== 1'b0) begin n_bad++; $display("FAIL conflict_width: got %b expected 0", o_err_conflict); end
    apply(K_GRN, P_BAD);
    n_vec++; if (o_err_code !== 1'b1 || o_phase !== 3'd2) begin n_bad++; $display("FAIL code_walker11: got code=%b phase=%0d expected 1/2", o_err_code, o_phase); end
    apply(K_GRN, P_RED);
    n_vec++; if (o_err_sticky !== 4'b1001) begin n_bad++; $display("FAIL conflict_sticky: got %b expected 1001", o_err_sticky); end
  endtask

  task automatic test_mid_operation();
    apply(K_YEL, P_RED);
    repeat (3) apply(K_LEFT, P_RED);
    n_vec++; if (o_phase !== 3'd4) begin n_bad++; $display("FAIL mid_in_left: got %0d expected 4", o_phase); end
    #2 reset = 1'b1;
    #1;
    n_vec++; if (o_phase !== 3'd0 || o_err_sticky !== 4'd0 || o_cycle_cnt !== 8'd0 || {o_err_code, o_err_seq, o_err_len, o_err_conflict} !== 4'b0) begin n_bad++; $display("FAIL async_reset: got phase=%0d sticky=%b cyc=%0d expected all 0", o_phase, o_err_sticky, o_cycle_cnt); end
    #1 reset = 1'b0;
    repeat (4) apply(K_RED, P_RED);
    apply(K_GRN, P_RED);
    apply(K_YEL, P_RED);
    apply(K_LEFT, P_RED);
    apply(K_YEL, P_RED);
    apply(K_RED, P_GRN);
    apply(K_RED, P_GRN);
    n_vec++; if (o_phase !== 3'd6 || o_err_sticky[1] !== 1'b1 || o_cycle_cnt !== 8'd1) begin n_bad++; $display("FAIL mid_pre_stop: got phase=%0d sticky=%b cyc=%0d expected 6/x1x/1", o_phase, o_err_sticky, o_cycle_cnt); end
    start = 1'b0;
    apply(K_RED, P_GRN);
    n_vec++; if (o_phase !== 3'd0 || o_err_sticky !== 4'd0 || o_cycle_cnt !== 8'd1 || {o_err_code, o_err_seq, o_err_len, o_err_conflict} !== 4'b0) begin n_bad++; $display("FAIL stop_in_red: got phase=%0d sticky=%b cyc=%0d expected 0/0000/1", o_phase, o_err_sticky, o_cycle_cnt); end
  endtask

  task automatic test_blink();
    int exp_code;
`ifdef TRAFFIC_MON_BLINK_CHK_EN
    exp_code = 1;
`else
    exp_code = 0;
`endif
    start = 1'b1;
    drive_phase(K_GRN, 21, 1'b0);
    drive_phase(K_YEL, 2, 1'b0);
    drive_phase(K_LEFT, 10, 1'b0);
    drive_phase(K_YEL, 2, 1'b0);
    clear_counts();
    drive_phase(K_RED, 34, 1'b1);
    n_vec++; if (cnt_code != exp_code) begin n_bad++; $display("FAIL blink_code_pulses: got %0d expected %0d", cnt_code, exp_code); end
    n_vec++; if (cnt_seq + cnt_len + cnt_conf != 0) begin n_bad++; $display("FAIL blink_other_errors: got %0d expected 0", cnt_seq + cnt_len + cnt_conf); end
  endtask

  initial begin
    clear_counts();
    test_reset();
    test_golden();
    test_short_left();
    test_skip();
    test_conflict();
    test_mid_operation();
    test_blink();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
